// File: rtl/magnitude_compare_seq.sv
// -----------------------------------------------------------------------------
// magnitude_compare_seq
//
// Sequential magnitude comparator. A request (a, b, op, signed_cmp) is
// captured on an accept edge, then the operands are compared one CHUNK-bit
// slice per cycle, most significant slice first. The finished relation is
// held in DONE until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE, and the
// result and flags are held stable there until out_ready is seen. The edge
// that retires a result never accepts a new request: in_ready rises the
// cycle after.
//
// Parameters
//   WIDTH       operand width in bits (2..64)
//   CHUNK       bits compared per cycle, must divide WIDTH
//   EARLY_EXIT  1 = stop at the first differing slice, 0 = always scan all
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   a, b                operands
//   op                  predicate: 0 GT, 1 LT, 2 EQ, 3 NE, 4 GE, 5 LE, 6/7 -> 0
//   signed_cmp          1 = two's-complement compare
//   out_valid/out_ready result handshake
//   result              selected predicate of a versus b
//   gt, lt, eq          relation flags (one-hot while out_valid, else 0)
//   busy                1 whenever the state is not IDLE
//   state_dbg           current FSM state (0 IDLE, 1 SCAN, 2 DONE)
// -----------------------------------------------------------------------------
module magnitude_compare_seq #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             signed_cmp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH < 2 || WIDTH > 64 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("magnitude_compare_seq: WIDTH must be 2..64 and divisible by CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic               result_q, result_d;
    // Sticky decision used when every slice is scanned regardless.
    logic               found_q, found_d;
    logic               sgt_q, sgt_d;

    logic [CHUNK-1:0]   chunk_a, chunk_b;
    logic               differ, chunk_gt;
    logic               finish, fin_gt, fin_lt, fin_eq;

    function automatic logic pred(input logic [2:0] o, input logic g,
                                  input logic l, input logic e);
        case (o)
            3'b000:  pred = g;
            3'b001:  pred = l;
            3'b010:  pred = e;
            3'b011:  pred = ~e;
            3'b100:  pred = g | e;
            3'b101:  pred = l | e;
            default: pred = 1'b0;
        endcase
    endfunction

    // Select the slice at the current index.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = a_q[i*CHUNK +: CHUNK];
                chunk_b = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        result_d = result_q;
        found_d  = found_q;
        sgt_d    = sgt_q;
        differ   = (chunk_a != chunk_b);
        chunk_gt = (chunk_a > chunk_b);
        finish   = 1'b0;
        fin_gt   = 1'b0;
        fin_lt   = 1'b0;
        fin_eq   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                    // Flipping both sign bits maps two's-complement order
                    // onto unsigned order, so the scan itself is unsigned.
                    if (signed_cmp) begin
                        a_d[WIDTH-1] = ~a[WIDTH-1];
                        b_d[WIDTH-1] = ~b[WIDTH-1];
                    end
                    op_d    = op;
                    idx_d   = IDX_W'(NCHUNK - 1);
                    found_d = 1'b0;
                    sgt_d   = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (differ && EARLY_EXIT != 0) begin
                    finish = 1'b1;
                    fin_gt = chunk_gt;
                    fin_lt = ~chunk_gt;
                end else begin
                    if (differ && !found_q) begin
                        found_d = 1'b1;
                        sgt_d   = chunk_gt;
                    end
                    if (idx_q == '0) begin
                        finish = 1'b1;
                        if (found_q) begin
                            fin_gt = sgt_q;
                            fin_lt = ~sgt_q;
                        end else if (differ) begin
                            fin_gt = chunk_gt;
                            fin_lt = ~chunk_gt;
                        end else begin
                            fin_eq = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                if (finish) begin
                    gt_d     = fin_gt;
                    lt_d     = fin_lt;
                    eq_d     = fin_eq;
                    result_d = pred(op_q, fin_gt, fin_lt, fin_eq);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b0;
                    result_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            result_q <= 1'b0;
            found_q  <= 1'b0;
            sgt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            result_q <= result_d;
            found_q  <= found_d;
            sgt_q    <= sgt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_magnitude_compare_seq.sv
// -----------------------------------------------------------------------------
// tb_magnitude_compare_seq
//
// Three instances share one stimulus bus: u0 (16/4, early exit), u1 (16/4,
// full scan) and u2 (32/8, early exit). sel gates in_valid to one instance
// and muxes that instance's outputs onto the observed signals. Inputs are
// driven 1 time unit after a rising edge and sampled at the same point.
// -----------------------------------------------------------------------------
module tb_magnitude_compare_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared stimulus bus ----------------
    int          sel = 0;
    logic        in_valid_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [2:0]  op_i = '0;
    logic        sc_i = 1'b0;
    logic        out_ready_i = 1'b0;

    logic iv0, iv1, iv2;
    assign iv0 = in_valid_i && (sel == 0);
    assign iv1 = in_valid_i && (sel == 1);
    assign iv2 = in_valid_i && (sel == 2);

    logic       ir0, ov0, r0, g0, l0, e0, bz0;
    logic       ir1, ov1, r1, g1, l1, e1, bz1;
    logic       ir2, ov2, r2, g2, l2, e2, bz2;
    logic [1:0] sd0, sd1, sd2;

    magnitude_compare_seq #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .a(a_i[15:0]), .b(b_i[15:0]), .op(op_i), .signed_cmp(sc_i),
        .out_valid(ov0), .out_ready(out_ready_i), .result(r0),
        .gt(g0), .lt(l0), .eq(e0), .busy(bz0), .state_dbg(sd0));

    magnitude_compare_seq #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a_i[15:0]), .b(b_i[15:0]), .op(op_i), .signed_cmp(sc_i),
        .out_valid(ov1), .out_ready(out_ready_i), .result(r1),
        .gt(g1), .lt(l1), .eq(e1), .busy(bz1), .state_dbg(sd1));

    magnitude_compare_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a(a_i), .b(b_i), .op(op_i), .signed_cmp(sc_i),
        .out_valid(ov2), .out_ready(out_ready_i), .result(r2),
        .gt(g2), .lt(l2), .eq(e2), .busy(bz2), .state_dbg(sd2));

    // Observed outputs of the selected instance.
    logic o_in_ready, o_out_valid, o_result, o_gt, o_lt, o_eq, o_busy;
    always_comb begin
        o_in_ready  = ir0;
        o_out_valid = ov0;
        o_result    = r0;
        o_gt        = g0;
        o_lt        = l0;
        o_eq        = e0;
        o_busy      = bz0;
        if (sel == 1) begin
            o_in_ready = ir1; o_out_valid = ov1; o_result = r1;
            o_gt = g1; o_lt = l1; o_eq = e1; o_busy = bz1;
        end else if (sel == 2) begin
            o_in_ready = ir2; o_out_valid = ov2; o_result = r2;
            o_gt = g2; o_lt = l2; o_eq = e2; o_busy = bz2;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic exp_pred(input logic [2:0] o, input logic g,
                                      input logic l, input logic e);
        case (o)
            3'd0:    return g;
            3'd1:    return l;
            3'd2:    return e;
            3'd3:    return !e;
            3'd4:    return g || e;
            3'd5:    return l || e;
            default: return 1'b0;
        endcase
    endfunction

    // Slices examined with early exit: position of the first nonzero slice
    // of a^b counted from the top, or all of them when a == b.
    function automatic int exp_chunks(input logic [31:0] x, input int nch, input int cw);
        logic [31:0] m;
        m = (32'h1 << cw) - 32'h1;
        for (int i = nch - 1; i >= 0; i--) begin
            if (((x >> (i * cw)) & m) != 32'h0) return nch - i;
        end
        return nch;
    endfunction

    // ---------------- driver + inline checks ----------------
    // exp_k < 0 skips the latency check.
    task automatic do_cmp(input int s, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [2:0] top, input logic tsc, input int exp_k,
                          input logic [3:0] exp_flags, input string nm);
        int k;
        logic [3:0] got;
        sel = s;
        #0;
        total++;
        if (o_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready_before: got %b want 1", nm, o_in_ready);
        end
        a_i = ta; b_i = tb; op_i = top; sc_i = tsc;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        step();                         // accept edge E0
        in_valid_i = 1'b0;
        // Scramble the inputs: the in-flight compare must ignore them.
        a_i = ~ta; b_i = ~tb; op_i = ~top; sc_i = ~tsc;
        k = 0;
        while (o_out_valid !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        total++;
        if (o_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: out_valid never rose in %0d cycles", nm, k);
        end else if (exp_k >= 0 && k != exp_k) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, k, exp_k);
        end
        got = {o_gt, o_lt, o_eq, o_result};
        total++;
        if (got !== exp_flags) begin
            bad++;
            $display("FAIL %s flags{gt,lt,eq,result}: got %b want %b", nm, got, exp_flags);
        end
        total++;
        if (o_in_ready !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s done_status: in_ready=%b busy=%b want 0/1", nm, o_in_ready, o_busy);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        got = {o_gt, o_lt, o_eq, o_result};
        total++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || got !== 4'b0000) begin
            bad++;
            $display("FAIL %s release: out_valid=%b in_ready=%b flags=%b want 0/1/0000",
                     nm, o_out_valid, o_in_ready, got);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] got;
        rst = 1'b1;
        in_valid_i = 1'b1;              // reset must win over a request
        step();
        step();
        rst = 1'b0;
        in_valid_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            got = {o_gt, o_lt, o_eq, o_result};
            total++;
            if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b1 || got !== 4'b0000) begin
                bad++;
                $display("FAIL reset_state_u%0d: out_valid=%b busy=%b in_ready=%b flags=%b want 0/0/1/0000",
                         s, o_out_valid, o_busy, o_in_ready, got);
            end
        end
    endtask

    task automatic test_unsigned();
        do_cmp(0, 32'h1234, 32'h1235, 3'd0, 1'b0, 4, 4'b0100, "u_gt_1234_1235");
        do_cmp(0, 32'hABCD, 32'hABCD, 3'd2, 1'b0, 4, 4'b0011, "u_eq_abcd");
        do_cmp(0, 32'h0F00, 32'h0E00, 3'd5, 1'b0, 2, 4'b1000, "u_le_0f00_0e00");
        do_cmp(0, 32'h5555, 32'h5554, 3'd3, 1'b0, 4, 4'b1001, "u_ne_5555_5554");
        do_cmp(0, 32'h0010, 32'h0001, 3'd6, 1'b0, 3, 4'b1000, "u_reserved_op");
    endtask

    task automatic test_early_exit();
        do_cmp(0, 32'h8000, 32'h7FFF, 3'd1, 1'b1, 1, 4'b0101, "ee_signed_lt");
        do_cmp(0, 32'h8000, 32'h7FFF, 3'd1, 1'b0, 1, 4'b1000, "ee_unsigned_lt");
        do_cmp(0, 32'hFFFF, 32'h0001, 3'd4, 1'b1, 1, 4'b0100, "ee_signed_ge_m1_1");
    endtask

    task automatic test_full_scan();
        do_cmp(1, 32'hBEEF, 32'hBEEF, 3'd4, 1'b0, 4, 4'b0011, "fs_ge_beef");
        do_cmp(1, 32'hBEEF, 32'hBEEF, 3'd3, 1'b0, 4, 4'b0010, "fs_ne_beef");
        // Low slice disagrees with the top one: decision must stick.
        do_cmp(1, 32'h8000, 32'h7FFF, 3'd0, 1'b0, 4, 4'b1001, "fs_sticky_gt");
        do_cmp(1, 32'h8000, 32'h7FFF, 3'd1, 1'b1, 4, 4'b0101, "fs_sticky_signed_lt");
    endtask

    task automatic test_wide();
        do_cmp(2, 32'hFFFFFFFF, 32'h00000001, 3'd5, 1'b1, 1, 4'b0101, "w32_signed_le");
        do_cmp(2, 32'h00000001, 32'h00000002, 3'd4, 1'b0, 4, 4'b0100, "w32_unsigned_ge");
    endtask

    task automatic test_back_pressure();
        logic [3:0] got;
        sel = 0;
        a_i = 32'h1234; b_i = 32'h1235; op_i = 3'd1; sc_i = 1'b0;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 5; i++) begin
            got = {o_gt, o_lt, o_eq, o_result};
            total++;
            if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || got !== 4'b0101) begin
                bad++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b flags=%b want 1/0/0101",
                         i, o_out_valid, o_in_ready, got);
            end
            step();
        end
        // A request waiting at the release edge must not be taken there.
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        total++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                     o_out_valid, o_in_ready, o_busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        sel = 0;
        a_i = 32'h1234; b_i = 32'h1235; op_i = 3'd0; sc_i = 1'b0;
        in_valid_i = 1'b1;
        step();                         // E0
        in_valid_i = 1'b0;
        step();                         // E1
        rst = 1'b1;
        step();                         // E2 samples reset
        rst = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_scan: busy=%b out_valid=%b want 0/0", o_busy, o_out_valid);
        end
        out_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_out_valid === 1'b1 || o_busy === 1'b1) seen++;
        end
        out_ready_i = 1'b0;
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rst_no_result: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, mk;
        logic [2:0]  rop;
        logic        rsc, eg, el, ee;
        longint      va, vb;
        int          w, nch, cw, k;
        string       nm;
        for (int n = 0; n < 36; n++) begin
            sel = n % 3;
            w   = (sel == 2) ? 32 : 16;
            cw  = (sel == 2) ? 8 : 4;
            nch = w / cw;
            mk  = (w == 32) ? 32'hFFFFFFFF : 32'h0000FFFF;
            ra  = $urandom() & mk;
            case ($urandom_range(0, 2))
                0:       rb = $urandom() & mk;
                1:       rb = ra;
                default: rb = (ra ^ (32'h1 << $urandom_range(0, w - 1))) & mk;
            endcase
            rop = 3'($urandom_range(0, 7));
            rsc = 1'($urandom_range(0, 1));
            if (w == 32) begin
                va = rsc ? longint'(signed'(ra)) : longint'(ra);
                vb = rsc ? longint'(signed'(rb)) : longint'(rb);
            end else begin
                va = rsc ? longint'(signed'(ra[15:0])) : longint'(ra[15:0]);
                vb = rsc ? longint'(signed'(rb[15:0])) : longint'(rb[15:0]);
            end
            eg = (va > vb);
            el = (va < vb);
            ee = (va == vb);
            k  = (sel == 1) ? nch : exp_chunks(ra ^ rb, nch, cw);
            nm = $sformatf("rand%0d_u%0d_%h_%h_op%0d_s%0d", n, sel, ra, rb, rop, rsc);
            do_cmp(sel, ra, rb, rop, rsc, k, {eg, el, ee, exp_pred(rop, eg, el, ee)}, nm);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_early_exit();
        test_full_scan();
        test_wide();
        test_back_pressure();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magnitude_compare_seq.md
MAGNITUDE_COMPARE_SEQ -- requirements
Module: magnitude_compare_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits (legal 2..64).
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits compared per cycle; CHUNK SHALL divide WIDTH, otherwise elaboration fails.
REQ-003 The block SHALL have parameter EARLY_EXIT, default 1, meaning 1 = stop scanning at the first differing chunk, 0 = always scan all chunks.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, a synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning a request is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a request.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each, the operands.
REQ-009 The block SHALL have port op, input, 3 bits, selecting the predicate: 000 GT, 001 LT, 010 EQ, 011 NE, 100 GE, 101 LE, 110/111 reserved.
REQ-010 The block SHALL have port signed_cmp, input, 1 bit, meaning 1 = two's-complement compare, 0 = unsigned compare.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning a result is present.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-013 The block SHALL have port result, output, 1 bit, the selected predicate of a versus b.
REQ-014 The block SHALL have ports gt, lt and eq, output, 1 bit each, the full relation flags; exactly one SHALL be 1 while out_valid=1.
REQ-015 The block SHALL have port busy, output, 1 bit, which is 1 whenever the state is not IDLE.

Function
REQ-016 The block SHALL use the states IDLE, SCAN and DONE, with NCHUNK = WIDTH/CHUNK.
REQ-017 In IDLE, the block SHALL drive in_ready=1; in SCAN and DONE, in_ready=0.
REQ-018 On an accept edge (in_valid & in_ready), the block SHALL register a, b, op and signed_cmp, set chunk index to NCHUNK-1, and go to SCAN.
REQ-019 When the registered signed_cmp=1, the block SHALL invert the MSB of both registered operands so that unsigned ordering gives signed ordering.
REQ-020 In SCAN, each cycle SHALL compare the one chunk at the index, proceeding MSB chunk first.
REQ-021 If the chunk differs and EARLY_EXIT=1, the block SHALL register gt/lt from that chunk and go to DONE.
REQ-022 If EARLY_EXIT=0, the first differing chunk SHALL set the sticky decision, and the block SHALL continue until index 0.
REQ-023 If index 0 is reached with no difference, the block SHALL set eq=1 and go to DONE.
REQ-024 Otherwise, the block SHALL decrement the index and stay in SCAN.
REQ-025 Latency: with the accept at edge E0, out_valid SHALL rise at edge Ek, where k = number of chunks examined (1..NCHUNK; always NCHUNK when EARLY_EXIT=0).
REQ-026 In DONE, the block SHALL hold out_valid=1 and keep result, gt, lt and eq stable until out_ready=1.
REQ-027 On the edge where out_valid & out_ready, the block SHALL go to IDLE; in_ready SHALL be 1 the following cycle, and no same-cycle accept SHALL occur.
REQ-028 result SHALL be derived from the registered op: GT=gt, LT=lt, EQ=eq, NE=~eq, GE=gt|eq, LE=lt|eq, reserved=0; gt, lt and eq SHALL remain valid for reserved op.
REQ-029 Input changes on a, b, op and signed_cmp outside an accept edge SHALL NOT affect an in-flight comparison.
REQ-030 While out_valid=0, the outputs result, gt, lt and eq SHALL be 0.

Reset
REQ-031 When rst=1 at an edge, the block SHALL go to IDLE, with out_valid=0, result=0, gt=0, lt=0, eq=0, busy=0, in_ready=1 the following cycle.
REQ-032 Reset SHALL take priority over in_valid and out_ready at the same edge.
REQ-033 Reset during SCAN or DONE SHALL discard the in-flight request, and no out_valid SHALL follow.

Verification
REQ-034 Unsigned, defaults: a=0x1234, b=0x1235, op=GT -> 4 chunks scanned, out_valid at E4, gt=0, lt=1, eq=0, result=0.
REQ-035 Early exit: a=0x8000, b=0x7FFF, signed_cmp=1, op=LT -> out_valid at E1, lt=1, result=1; the same operands with signed_cmp=0 -> gt=1, result=0.
REQ-036 Equality with EARLY_EXIT=0: a=b=0xBEEF, op=GE -> out_valid at E4, eq=1, result=1; the same operands with op=NE -> result=0.
REQ-037 Back-pressure: out_ready held 0 for 5 cycles after out_valid -> out_valid and the flags stay stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-038 Reset mid-SCAN: assert rst at E2 of a 4-chunk compare -> at the next edge busy=0 and out_valid=0; no result appears afterwards.
REQ-039 WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, signed_cmp=1, op=LE -> out_valid at E1, lt=1, result=1; random signed and unsigned sweep matches the reference model.
